// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and lane helpers for the load/store memory controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } lsu_state_e;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // Only the five size/sign encodings are meaningful; 011, 110 and 111 are rejected.
  function automatic logic funct3_legal(input logic [2:0] f3);
    return f3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
  endfunction

  // Halves need an even address, words a 4-byte aligned one; bytes are always fine.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Byte enables for the addressed lane(s); loads and stores use the same pattern.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data across every lane so byte enables pick it out.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus: a valid/ack request channel from the LSU to the memory.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension according to funct3.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path infers a latch.
    data     = rdata;
    byte_sel = rdata[7:0];
    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      FUNCT3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_LH:  data = {{16{half_sel[15]}}, half_sel};
      FUNCT3_LBU: data = {24'h0, byte_sel};
      FUNCT3_LHU: data = {16'h0, half_sel};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage LSU: turns a registered load/store request into one valid/ack bus
// transaction, stalls the pipeline until it completes, and aligns load data.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              err,
  lsu_mem_ctrl_if.master    bus
);

  // Last counter value before giving up; the request spends TIMEOUT cycles in REQ.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  lsu_state_e        state;
  logic [15:0]       cnt;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       load_data_q;
  logic              load_valid_q;
  logic              err_q;
  logic [31:0]       aligned;

  // Request decode: any enable is an access; a bad one is reported instead of issued.
  logic acc, bad, start;
  assign acc   = rd_en | wr_en;
  assign bad   = acc && ((rd_en && wr_en) || !funct3_legal(funct3) || misaligned(funct3, addr[1:0]));
  assign start = (state == IDLE) && acc && !bad;

  // Stall rises in the accept cycle itself so the request stays put until DONE.
  assign stall = start || (state == REQ);

  lsu_load_align u_align (
    .rdata  (bus.mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (aligned)
  );

  // Transaction FSM with latched bus fields, timeout counter and pulse outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      off_q        <= '0;
      f3_q         <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bad) begin
            err_q <= 1'b1;
          end else if (acc) begin
            we_q    <= wr_en;
            addr_q  <= {addr[ADDR_W-1:2], 2'b00};
            off_q   <= addr[1:0];
            f3_q    <= funct3;
            be_q    <= byte_en(funct3, addr[1:0]);
            wdata_q <= store_lanes(funct3, wdata);
            req_q   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            req_q <= 1'b0;
            state <= DONE;
            if (!we_q) begin
              load_data_q  <= aligned;
              load_valid_q <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            req_q <= 1'b0;
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign load_data     = load_data_q;
  assign load_valid    = load_valid_q;
  assign err           = err_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: expected load results go into a scoreboard
// queue when a load is issued and are popped when load_valid fires.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en, wr_en;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, err;
  logic [31:0] load_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .err        (err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access; ack arrives in REQ cycle number ack_dly (0 = first).
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                        input int ack_dly, input logic [3:0] e_be, input logic [31:0] e_addr,
                        input logic [31:0] e_wdata, input logic [31:0] e_load);
    int nstall = 0;
    @(negedge clk);
    rd_en = rd; wr_en = wr; funct3 = f3; addr = a; wdata = wd;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h5A5A_5A5A;
    if (rd) sb.push_back(e_load);
    #1;
    if (stall === 1'b1) nstall++;
    for (int i = 0; i <= ack_dly; i++) begin
      @(negedge clk);
      if (stall === 1'b1) nstall++;
      check({tag, "_req"}, {31'b0, bus.mem_req}, 32'd1);
      check({tag, "_lv_in_req"}, {31'b0, load_valid}, 32'd0);
      if (i == 0) begin
        check({tag, "_we"}, {31'b0, bus.mem_we}, {31'b0, wr});
        check({tag, "_addr"}, bus.mem_addr, e_addr);
        check({tag, "_be"}, {28'b0, bus.mem_be}, {28'b0, e_be});
        if (wr) check({tag, "_wdata"}, bus.mem_wdata, e_wdata);
      end
      if (i == ack_dly) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
      end
    end
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h5A5A_5A5A;
    if (stall === 1'b1) nstall++;
    check({tag, "_done_req"}, {31'b0, bus.mem_req}, 32'd0);
    check({tag, "_stall_cycles"}, nstall, ack_dly + 2);
    check({tag, "_load_valid"}, {31'b0, load_valid}, {31'b0, rd});
    if (load_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        check({tag, "_load_data"}, load_data, sb.pop_front());
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check({tag, "_lv_pulse"}, {31'b0, load_valid}, 32'd0);
  endtask

  // A rejected request: no bus activity, no stall, one err pulse.
  task automatic bad_req(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a);
    @(negedge clk);
    rd_en = rd; wr_en = wr; funct3 = f3; addr = a; wdata = 32'h0;
    #1;
    check({tag, "_stall0"}, {31'b0, stall}, 32'd0);
    @(negedge clk);
    check({tag, "_err"}, {31'b0, err}, 32'd1);
    check({tag, "_noreq"}, {31'b0, bus.mem_req}, 32'd0);
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check({tag, "_err_pulse"}, {31'b0, err}, 32'd0);
    check({tag, "_noreq2"}, {31'b0, bus.mem_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_lv", {31'b0, load_valid}, 32'd0);
    check("rst_ld", load_data, 32'h0);
    check("rst_be", {28'b0, bus.mem_be}, 32'h0);
    reset = 1'b0;

    // Loads
    access("lw",  1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h10, 32'h0, 32'hDEAD_BEEF);
    access("lb",  1, 0, 3'b000, 32'h13, 32'h0, 32'h8011_2233, 2, 4'b1000, 32'h10, 32'h0, 32'hFFFF_FF80);
    access("lbu", 1, 0, 3'b100, 32'h13, 32'h0, 32'h8011_2233, 0, 4'b1000, 32'h10, 32'h0, 32'h0000_0080);
    access("lh",  1, 0, 3'b001, 32'h12, 32'h0, 32'h8011_2233, 1, 4'b1100, 32'h10, 32'h0, 32'hFFFF_8011);
    access("lhu", 1, 0, 3'b101, 32'h14, 32'h0, 32'h1234_F00D, 0, 4'b0011, 32'h14, 32'h0, 32'h0000_F00D);

    // Stores
    access("sb", 0, 1, 3'b000, 32'h05, 32'h1234_56A5, 32'h0, 0, 4'b0010, 32'h04, 32'hA5A5_A5A5, 32'h0);
    access("sh", 0, 1, 3'b001, 32'h22, 32'h0000_ABCD, 32'h0, 3, 4'b1100, 32'h20, 32'hABCD_ABCD, 32'h0);
    access("sw", 0, 1, 3'b010, 32'h30, 32'hCAFE_F00D, 32'h0, 1, 4'b1111, 32'h30, 32'hCAFE_F00D, 32'h0);
    check("ld_hold", load_data, 32'h0000_F00D);

    // Rejected requests
    bad_req("lw_mis", 1, 0, 3'b010, 32'h02);
    bad_req("lh_mis", 1, 0, 3'b001, 32'h01);
    bad_req("f3_011", 1, 0, 3'b011, 32'h00);
    bad_req("rd_wr",  1, 1, 3'b010, 32'h00);

    // Timeout: no ack for TIMEOUT=4 cycles
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b0; funct3 = 3'b010; addr = 32'h40;
    bus.mem_ack = 1'b0;
    #1;
    check("to_stall0", {31'b0, stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_req", {31'b0, bus.mem_req}, 32'd1);
      check("to_noerr", {31'b0, err}, 32'd0);
      if (i == 3) rd_en = 1'b0;
    end
    @(negedge clk);
    check("to_req_drop", {31'b0, bus.mem_req}, 32'd0);
    check("to_err", {31'b0, err}, 32'd1);
    check("to_stall", {31'b0, stall}, 32'd0);
    check("to_lv", {31'b0, load_valid}, 32'd0);
    @(negedge clk);
    check("to_err_pulse", {31'b0, err}, 32'd0);

    // Reset while in REQ, then a late ack
    @(negedge clk);
    rd_en = 1'b1; funct3 = 3'b010; addr = 32'h44;
    @(negedge clk);
    check("rs_req", {31'b0, bus.mem_req}, 32'd1);
    reset = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rs_req0", {31'b0, bus.mem_req}, 32'd0);
    check("rs_stall0", {31'b0, stall}, 32'd0);
    check("rs_err0", {31'b0, err}, 32'd0);
    check("rs_ld0", load_data, 32'h0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("late_ack_lv", {31'b0, load_valid}, 32'd0);
    check("late_ack_req", {31'b0, bus.mem_req}, 32'd0);
    check("late_ack_stall", {31'b0, stall}, 32'd0);
    check("late_ack_ld", load_data, 32'h0);

    // Normal operation resumes after reset
    access("lw2", 1, 0, 3'b010, 32'h48, 32'h0, 32'h0BAD_F00D, 1, 4'b1111, 32'h48, 32'h0, 32'h0BAD_F00D);

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
